bus_slice_sequencer: RTL and testbench

- Controller for a source-to-sink bus datapath. It copies a captured source word into a registered sink word one slice per cycle.
- Slices are programmed as bit ranges in a small table and applied in table order. Ranges may be ascending or descending, e.g. [3], then [1:2], then [0].
- Sits between a producer (valid/ready in) and a consumer (valid/ready out). Sequences the slice assigns deterministically and flags bad or overlapping slice maps.

---
 rtl/bus_seq_pkg.sv | 31 +++
 rtl/bus_slice_table.sv | 60 ++++++
 rtl/bus_slice_sequencer.sv | 133 +++++++++++++
 tb/tb_bus_slice_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// Shared types and helpers for the bus slice sequencer: FSM states, slice table entry
// and the range-to-mask helper used by the datapath.
package bus_seq_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam int unsigned MaxWidth = 32;
  localparam int unsigned EntryW   = 8;

  typedef struct packed {
    logic [EntryW-1:0] lo;
    logic [EntryW-1:0] hi;
  } slice_entry_t;

  // Mask of bits min(lo,hi)..max(lo,hi) inside a bus of 'width' bits; oob flags hi' >= width.
  function automatic logic [MaxWidth-1:0] range_mask(input logic [EntryW-1:0] lo,
                                                     input logic [EntryW-1:0] hi,
                                                     input int unsigned       width,
                                                     output logic             oob);
    int unsigned a;
    int unsigned b;
    a = (lo < hi) ? 32'(lo) : 32'(hi);
    b = (lo < hi) ? 32'(hi) : 32'(lo);
    oob = (b >= width);
    range_mask = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width && i >= a && i <= b) range_mask[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/bus_slice_table.sv
// Slice table register file with one write port, one async read port and the
// saturating active-count register.
module bus_slice_table
  import bus_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MAX_SLICES = 4,
  parameter int unsigned IW         = 2,
  parameter int unsigned BW         = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic          i_cfg_we,
  input  logic [IW-1:0] i_cfg_idx,
  input  logic [BW-1:0] i_cfg_lo,
  input  logic [BW-1:0] i_cfg_hi,
  input  logic          i_cfg_count_we,
  input  logic [IW:0]   i_cfg_count,
  input  logic [IW-1:0] i_rd_idx,
  output slice_entry_t  o_entry,
  output logic [IW:0]   o_count,
  output logic [IW:0]   o_count_nxt
);

  logic [BW-1:0] r_lo [MAX_SLICES];
  logic [BW-1:0] r_hi [MAX_SLICES];
  logic [IW:0]   r_count;
  logic [IW:0]   w_count_sat;

  assign w_count_sat = (32'(i_cfg_count) > MAX_SLICES) ? (IW+1)'(MAX_SLICES) : i_cfg_count;
  // Count as it will be after this cycle, so a capture sees a same-cycle count write.
  assign o_count_nxt = (i_wr_en && i_cfg_count_we) ? w_count_sat : r_count;
  assign o_count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_SLICES); i++) begin
        r_lo[i] <= '0;
        r_hi[i] <= '0;
      end
      r_count <= '0;
    end else if (i_wr_en) begin
      if (i_cfg_we && 32'(i_cfg_idx) < MAX_SLICES) begin
        r_lo[i_cfg_idx] <= i_cfg_lo;
        r_hi[i_cfg_idx] <= i_cfg_hi;
      end
      if (i_cfg_count_we) r_count <= w_count_sat;
    end
  end

  always_comb begin
    o_entry = '0;
    if (32'(i_rd_idx) < MAX_SLICES) begin
      o_entry.lo = EntryW'(r_lo[i_rd_idx]);
      o_entry.hi = EntryW'(r_hi[i_rd_idx]);
    end
  end

endmodule

// File: rtl/bus_slice_sequencer.sv
// Captures a source word and builds the sink word one table slice per cycle,
// flagging out-of-range and overlapping slices.
module bus_slice_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned  WIDTH      = 4,
  parameter int unsigned  MAX_SLICES = 4,
  localparam int unsigned IW         = (MAX_SLICES > 1) ? $clog2(MAX_SLICES) : 1,
  localparam int unsigned BW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [BW-1:0]    cfg_lo,
  input  logic [BW-1:0]    cfg_hi,
  input  logic             cfg_count_we,
  input  logic [IW:0]      cfg_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] source_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sink_bus,
  output logic             err,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_src;
  logic [WIDTH-1:0] r_sink;
  logic [WIDTH-1:0] r_written;
  logic             r_err;
  logic             r_out_valid;
  logic [IW-1:0]    r_ptr;

  logic             w_idle;
  slice_entry_t     w_entry;
  logic [IW:0]      w_count;
  logic [IW:0]      w_count_nxt;
  logic [MaxWidth-1:0] w_mask_full;
  logic [WIDTH-1:0] w_mask;
  logic             w_oob;
  logic             w_unused_mask;

  assign w_idle    = (r_state == IDLE);
  assign in_ready  = w_idle;
  assign busy      = !w_idle;
  assign out_valid = r_out_valid;
  assign sink_bus  = r_sink;
  assign err       = r_err;

  bus_slice_table #(
    .WIDTH      (WIDTH),
    .MAX_SLICES (MAX_SLICES),
    .IW         (IW),
    .BW         (BW)
  ) u_table (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_wr_en        (w_idle),
    .i_cfg_we       (cfg_we),
    .i_cfg_idx      (cfg_idx),
    .i_cfg_lo       (cfg_lo),
    .i_cfg_hi       (cfg_hi),
    .i_cfg_count_we (cfg_count_we),
    .i_cfg_count    (cfg_count),
    .i_rd_idx       (r_ptr),
    .o_entry        (w_entry),
    .o_count        (w_count),
    .o_count_nxt    (w_count_nxt)
  );

  always_comb begin
    w_oob       = 1'b0;
    w_mask_full = range_mask(w_entry.lo, w_entry.hi, WIDTH, w_oob);
  end

  assign w_mask        = w_mask_full[WIDTH-1:0];
  assign w_unused_mask = ^w_mask_full[MaxWidth-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_sink      <= '0;
      r_written   <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_src     <= source_bus;
            r_sink    <= '0;
            r_written <= '0;
            r_err     <= 1'b0;
            r_ptr     <= '0;
            if (w_count_nxt != '0) begin
              r_state <= XFER;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        XFER: begin
          if (w_oob) begin
            r_err <= 1'b1;
          end else begin
            r_sink    <= (r_sink & ~w_mask) | (r_src & w_mask);
            r_written <= r_written | w_mask;
            if ((r_written & w_mask) != '0) r_err <= 1'b1;
          end
          r_ptr <= r_ptr + IW'(1);
          if ({1'b0, r_ptr} == w_count - (IW+1)'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slice_sequencer.sv
// Randomised and directed bench for bus_slice_sequencer against a behavioural slice model.
module tb_bus_slice_sequencer;

  localparam int W  = 4;
  localparam int MS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [1:0] cfg_lo = '0;
  logic [1:0] cfg_hi = '0;
  logic       cfg_count_we = 1'b0;
  logic [2:0] cfg_count = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] source_bus = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] sink_bus;
  logic       err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_lo[MS];
  int m_hi[MS];
  int m_count;

  bus_slice_sequencer #(
    .WIDTH      (W),
    .MAX_SLICES (MS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_lo       (cfg_lo),
    .cfg_hi       (cfg_hi),
    .cfg_count_we (cfg_count_we),
    .cfg_count    (cfg_count),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .source_bus   (source_bus),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sink_bus     (sink_bus),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < MS; i++) begin
      m_lo[i] = 0;
      m_hi[i] = 0;
    end
    m_count = 0;
  endfunction

  // Apply each slice in order: copy bits, note overlap, skip ranges past the bus.
  function automatic void model(input logic [3:0] src, output logic [3:0] sink, output logic e);
    logic [3:0] written;
    int a, b;
    sink = '0;
    e = 1'b0;
    written = '0;
    for (int k = 0; k < m_count; k++) begin
      a = (m_lo[k] < m_hi[k]) ? m_lo[k] : m_hi[k];
      b = (m_lo[k] < m_hi[k]) ? m_hi[k] : m_lo[k];
      if (b >= W) begin
        e = 1'b1;
      end else begin
        for (int i = a; i <= b; i++) begin
          if (written[i]) e = 1'b1;
          written[i] = 1'b1;
          sink[i] = src[i];
        end
      end
    end
  endfunction

  task automatic cfg_entry(input int idx, input int lo, input int hi);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_idx = idx[1:0];
    cfg_lo = lo[1:0];
    cfg_hi = hi[1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    m_lo[idx] = lo;
    m_hi[idx] = hi;
  endtask

  task automatic cfg_cnt(input int c);
    @(negedge clk);
    cfg_count_we = 1'b1;
    cfg_count = c[2:0];
    @(negedge clk);
    cfg_count_we = 1'b0;
    m_count = (c > MS) ? MS : c;
  endtask

  task automatic send(input logic [3:0] src, input int hold, input bit cw, input int cidx,
                      input int clo, input int chi, input bit ccw, input int ccnt,
                      input bit gate);
    logic [3:0] esink;
    logic       eerr;
    int         lat;
    int         n;
    bit         got;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    source_bus = src;
    cfg_we = cw;
    cfg_idx = cidx[1:0];
    cfg_lo = clo[1:0];
    cfg_hi = chi[1:0];
    cfg_count_we = ccw;
    cfg_count = ccnt[2:0];
    if (cw) begin
      m_lo[cidx] = clo;
      m_hi[cidx] = chi;
    end
    if (ccw) m_count = (ccnt > MS) ? MS : ccnt;
    model(src, esink, eerr);
    lat = m_count + 1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        cfg_we = gate;
        cfg_count_we = gate;
        if (gate) begin
          cfg_idx = 2'd0;
          cfg_lo = 2'd3;
          cfg_hi = 2'd0;
          cfg_count = 3'd4;
        end
      end else if (n == 2) begin
        cfg_we = 1'b0;
        cfg_count_we = 1'b0;
      end
      if (out_valid) got = 1'b1;
    end
    cfg_we = 1'b0;
    cfg_count_we = 1'b0;
    check("latency", 32'(n), 32'(lat));
    check("sink", 32'(sink_bus), 32'(esink));
    check("err", 32'(err), 32'(eerr));
    check("busy_done", 32'(busy), 32'd1);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sink", 32'(sink_bus), 32'(esink));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_fall", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sink", 32'(sink_bus), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Shuffled map
    cfg_entry(0, 3, 3);
    cfg_entry(1, 1, 2);
    cfg_entry(2, 0, 0);
    cfg_cnt(3);
    send(4'b1011, 0, 0, 0, 0, 0, 0, 0, 0);

    // Descending and ascending ranges
    cfg_entry(0, 2, 1);
    cfg_cnt(1);
    send(4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
    cfg_entry(0, 1, 2);
    send(4'hF, 0, 0, 0, 0, 0, 0, 0, 0);

    // Overlap with uncovered bits
    cfg_entry(0, 0, 1);
    cfg_entry(1, 1, 1);
    cfg_cnt(2);
    send(4'hF, 0, 0, 0, 0, 0, 0, 0, 0);

    // Empty map with a stalled consumer
    cfg_cnt(0);
    send(4'hA, 5, 0, 0, 0, 0, 0, 0, 0);

    // Config writes while busy are dropped
    cfg_entry(0, 1, 2);
    cfg_cnt(1);
    send(4'h5, 0, 0, 0, 0, 0, 0, 0, 1);
    send(4'h5, 0, 0, 0, 0, 0, 0, 0, 0);
    cfg_entry(0, 3, 0);
    send(4'h5, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-transfer
    cfg_entry(0, 0, 0);
    cfg_entry(1, 1, 1);
    cfg_entry(2, 2, 3);
    cfg_cnt(3);
    @(negedge clk);
    in_valid = 1'b1;
    source_bus = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sink", 32'(sink_bus), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send(4'hA, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random maps, same-cycle config writes and consumer stalls
    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int k = 0; k < nw; k++) begin
        cfg_entry(int'($urandom_range(0, MS - 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 2) == 0) cfg_cnt(int'($urandom_range(0, 7)));
      send(4'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
           int'($urandom_range(0, MS - 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
